// File: rtl/branch_unit.sv
// Branch resolution unit: S1 holds the incoming op, S2 holds the resolved result.
// Resolution is combinational from S1; redirect pulses for one cycle alongside the first out_valid.
module branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_pred_taken,
  input  logic [31:0] in_pred_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_taken,
  output logic [31:0] out_next_pc,
  output logic [31:0] out_link,
  output logic        out_mispredict,
  output logic        out_illegal,
  output logic        out_misaligned,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  logic        s1_valid_q;
  logic [1:0]  kind_q;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q, rs1_q, rs2_q, imm_q, pred_target_q;
  logic        pred_taken_q;

  logic        s2_valid_q, taken_q, mispredict_q, illegal_q, misaligned_q;
  logic [31:0] next_pc_q, link_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] perf_branches_q, perf_mispredicts_q;

  logic        cmp_d, illegal_d, taken_d, misaligned_d, mispredict_d;
  logic [31:0] target_d, link_d, next_pc_d, jalr_sum;
  logic        s1_adv, adv_go, accept;

  assign jalr_sum = rs1_q + imm_q;
  assign link_d   = pc_q + 32'd4;

  always_comb begin
    cmp_d     = 1'b0;
    illegal_d = 1'b0;
    taken_d   = 1'b0;
    target_d  = pc_q + imm_q;
    unique case (funct3_q)
      3'd0:    cmp_d = (rs1_q == rs2_q);
      3'd1:    cmp_d = (rs1_q != rs2_q);
      3'd4:    cmp_d = ($signed(rs1_q) <  $signed(rs2_q));
      3'd5:    cmp_d = ($signed(rs1_q) >= $signed(rs2_q));
      3'd6:    cmp_d = (rs1_q <  rs2_q);
      3'd7:    cmp_d = (rs1_q >= rs2_q);
      default: cmp_d = 1'b0;
    endcase
    unique case (kind_q)
      2'd0: begin
        illegal_d = (funct3_q == 3'd2) || (funct3_q == 3'd3);
        taken_d   = cmp_d && !illegal_d;
      end
      2'd1: taken_d = 1'b1;
      2'd2: begin
        taken_d  = 1'b1;
        target_d = {jalr_sum[31:1], 1'b0};
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Illegal and misaligned ops never redirect, so they are excluded from mispredict.
  assign misaligned_d = taken_d && target_d[1];
  assign next_pc_d    = taken_d ? target_d : link_d;
  assign mispredict_d = !illegal_d && !misaligned_d &&
                        ((taken_d != pred_taken_q) || (taken_d && (target_d != pred_target_q)));

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign adv_go   = s1_adv && !flush;
  assign in_ready = (!s1_valid_q || s1_adv) && !(s1_adv && mispredict_d) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      kind_q        <= '0;
      funct3_q      <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      if (flush)          s1_valid_q <= 1'b0;
      else if (accept)    s1_valid_q <= 1'b1;
      else if (s1_adv)    s1_valid_q <= 1'b0;
      if (accept) begin
        kind_q        <= in_kind;
        funct3_q      <= in_funct3;
        pc_q          <= in_pc;
        rs1_q         <= in_rs1;
        rs2_q         <= in_rs2;
        imm_q         <= in_imm;
        pred_taken_q  <= in_pred_taken;
        pred_target_q <= in_pred_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q         <= 1'b0;
      taken_q            <= 1'b0;
      next_pc_q          <= '0;
      link_q             <= '0;
      mispredict_q       <= 1'b0;
      illegal_q          <= 1'b0;
      misaligned_q       <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      if (flush)          s2_valid_q <= 1'b0;
      else if (adv_go)    s2_valid_q <= 1'b1;
      else if (out_ready) s2_valid_q <= 1'b0;
      if (adv_go) begin
        taken_q         <= taken_d;
        next_pc_q       <= next_pc_d;
        link_q          <= link_d;
        mispredict_q    <= mispredict_d;
        illegal_q       <= illegal_d;
        misaligned_q    <= misaligned_d;
        perf_branches_q <= perf_branches_q + 32'd1;
        if (mispredict_d) begin
          perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
          redirect_pc_q      <= next_pc_d;
        end
      end
      redirect_valid_q <= adv_go && mispredict_d;
    end
  end

  assign out_valid        = s2_valid_q;
  assign out_taken        = taken_q;
  assign out_next_pc      = next_pc_q;
  assign out_link         = link_q;
  assign out_mispredict   = mispredict_q;
  assign out_illegal      = illegal_q;
  assign out_misaligned   = misaligned_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: each task drives one scenario and checks against hand-derived values.
module tb_branch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pred_target = '0;
  logic        in_pred_taken = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_taken, out_mispredict, out_illegal, out_misaligned, redirect_valid;
  logic [31:0] out_next_pc, out_link, redirect_pc, perf_branches, perf_mispredicts;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mp = 0;

  branch_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_funct3(in_funct3),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_next_pc(out_next_pc), .out_link(out_link), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .out_misaligned(out_misaligned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic pt, input logic [31:0] ptgt);
    in_valid = 1'b1; in_kind = k; in_funct3 = f3; in_pc = pc; in_rs1 = a; in_rs2 = b;
    in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", redirect_valid); end
    checks++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_branches, perf_mispredicts); end
    checks++; if (out_next_pc !== 32'd0) begin errors++; $display("FAIL reset_next_pc: got %h expected 0", out_next_pc); end
    tick; rst_n = 1'b1; tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_beq;
    out_ready = 1'b1;
    drive_op(2'd0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h40, 1'b1, 32'h140);
    tick; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL beq_in_ready: got %b expected 1", in_ready); end
    tick; exp_br++;
    checks++; if (out_valid !== 1'b1 || out_taken !== 1'b1) begin errors++; $display("FAIL beq_valid_taken: got %b%b expected 11", out_valid, out_taken); end
    checks++; if (out_next_pc !== 32'h140 || out_link !== 32'h104) begin errors++; $display("FAIL beq_pc_link: got %h/%h expected 140/104", out_next_pc, out_link); end
    checks++; if (out_mispredict !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_no_redirect: got %b%b expected 00", out_mispredict, redirect_valid); end
    checks++; if (perf_branches !== exp_br) begin errors++; $display("FAIL beq_perf: got %0d expected %0d", perf_branches, exp_br); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL beq_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_blt;
    drive_op(2'd0, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    tick; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL blt_in_ready: got %b expected 0", in_ready); end
    tick; exp_br++; exp_mp++;
    checks++; if (out_taken !== 1'b1 || out_mispredict !== 1'b1) begin errors++; $display("FAIL blt_taken_mp: got %b%b expected 11", out_taken, out_mispredict); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h210) begin errors++; $display("FAIL blt_redirect: got %b %h expected 1 210", redirect_valid, redirect_pc); end
    checks++; if (perf_mispredicts !== exp_mp) begin errors++; $display("FAIL blt_perf_mp: got %0d expected %0d", perf_mispredicts, exp_mp); end
    tick;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL blt_redirect_pulse: got %b expected 0", redirect_valid); end
    drive_op(2'd0, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    tick; in_valid = 1'b0; tick; exp_br++;
    checks++; if (out_taken !== 1'b0 || out_next_pc !== 32'h204 || out_mispredict !== 1'b0) begin errors++; $display("FAIL bltu_result: got %b %h %b expected 0 204 0", out_taken, out_next_pc, out_mispredict); end
    tick;
  endtask

  task automatic test_jump;
    drive_op(2'd2, 3'd0, 32'h800, 32'h1003, 32'd0, 32'h4, 1'b1, 32'h1006);
    tick; in_valid = 1'b0; tick; exp_br++;
    checks++; if (out_next_pc !== 32'h1006 || out_mispredict !== 1'b0) begin errors++; $display("FAIL jalr_target: got %h %b expected 1006 0", out_next_pc, out_mispredict); end
    checks++; if (out_misaligned !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL jalr_1006_misaligned: got %b %b expected 1 0", out_misaligned, redirect_valid); end
    tick;
    drive_op(2'd2, 3'd0, 32'h800, 32'h1001, 32'd0, 32'h1, 1'b0, 32'h0);
    tick; in_valid = 1'b0; tick; exp_br++;
    checks++; if (out_misaligned !== 1'b1 || out_next_pc !== 32'h1002 || redirect_valid !== 1'b0 || out_mispredict !== 1'b0) begin errors++; $display("FAIL jalr_misaligned: got %b %h %b %b expected 1 1002 0 0", out_misaligned, out_next_pc, redirect_valid, out_mispredict); end
    tick;
    drive_op(2'd1, 3'd0, 32'h300, 32'd0, 32'd0, 32'h20, 1'b1, 32'h320);
    tick; in_valid = 1'b0; tick; exp_br++;
    checks++; if (out_taken !== 1'b1 || out_next_pc !== 32'h320 || out_mispredict !== 1'b0 || out_misaligned !== 1'b0) begin errors++; $display("FAIL jal_ok: got %b %h %b %b expected 1 320 0 0", out_taken, out_next_pc, out_mispredict, out_misaligned); end
    tick;
    drive_op(2'd1, 3'd0, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 1'b0, 32'h0);
    tick; in_valid = 1'b0; tick; exp_br++; exp_mp++;
    checks++; if (out_next_pc !== 32'h10 || out_link !== 32'hFFFF_FFF4 || redirect_pc !== 32'h10 || redirect_valid !== 1'b1) begin errors++; $display("FAIL jal_wrap: got %h %h %h %b expected 10 fffffff4 10 1", out_next_pc, out_link, redirect_pc, redirect_valid); end
    tick;
  endtask

  task automatic test_illegal;
    drive_op(2'd0, 3'd2, 32'h400, 32'd1, 32'd1, 32'h80, 1'b1, 32'h480);
    tick; in_valid = 1'b0; tick; exp_br++;
    checks++; if (out_illegal !== 1'b1 || out_taken !== 1'b0 || out_next_pc !== 32'h404) begin errors++; $display("FAIL illegal_f3: got %b %b %h expected 1 0 404", out_illegal, out_taken, out_next_pc); end
    checks++; if (redirect_valid !== 1'b0 || out_mispredict !== 1'b0 || perf_mispredicts !== exp_mp) begin errors++; $display("FAIL illegal_no_mp: got %b %b %0d expected 0 0 %0d", redirect_valid, out_mispredict, perf_mispredicts, exp_mp); end
    tick;
    drive_op(2'd3, 3'd0, 32'h500, 32'd0, 32'd0, 32'h8, 1'b1, 32'h508);
    tick; in_valid = 1'b0; tick; exp_br++;
    checks++; if (out_illegal !== 1'b1 || out_next_pc !== 32'h504 || redirect_valid !== 1'b0) begin errors++; $display("FAIL illegal_kind3: got %b %h %b expected 1 504 0", out_illegal, out_next_pc, redirect_valid); end
    tick;
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    logic acc, hs, prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] opc;
    prev_stall = 1'b0; prev_pc = '0;
    while (got < 8 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      if (idx < 8) begin
        opc = 32'h1000 + idx * 32'h10;
        drive_op(2'd1, 3'd0, opc, 32'd0, 32'd0, 32'h100, 1'b1, opc + 32'h100);
      end else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_next_pc !== prev_pc) begin errors++; $display("FAIL b2b_hold: got %b %h expected 1 %h", out_valid, out_next_pc, prev_pc); end
      end
      acc = in_valid && in_ready;
      hs = out_valid && out_ready;
      if (hs) begin
        checks++; if (out_next_pc !== 32'h1100 + got * 32'h10) begin errors++; $display("FAIL b2b_order: got %h expected %h", out_next_pc, 32'h1100 + got * 32'h10); end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pc = out_next_pc;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    exp_br = exp_br + 8;
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
    tick;
    checks++; if (out_valid !== 1'b0 || perf_branches !== exp_br) begin errors++; $display("FAIL b2b_drain: got %b %0d expected 0 %0d", out_valid, perf_branches, exp_br); end
  endtask

  task automatic test_flush;
    drive_op(2'd0, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    tick;
    flush = 1'b1;
    drive_op(2'd1, 3'd0, 32'h600, 32'd0, 32'd0, 32'h8, 1'b1, 32'h608);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick; flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b %b expected 0 0", out_valid, redirect_valid); end
    checks++; if (perf_branches !== exp_br || perf_mispredicts !== exp_mp) begin errors++; $display("FAIL flush_perf: got %0d/%0d expected %0d/%0d", perf_branches, perf_mispredicts, exp_br, exp_mp); end
    tick;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b %b expected 0 0", out_valid, redirect_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive_op(2'd0, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    tick;
    drive_op(2'd1, 3'd0, 32'h700, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0);
    tick; in_valid = 1'b0;
    #2; rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin errors++; $display("FAIL rst_mid_out: got %b %b %h expected 0 0 0", out_valid, redirect_valid, redirect_pc); end
    checks++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0 || out_next_pc !== 32'd0) begin errors++; $display("FAIL rst_mid_perf: got %0d %0d %h expected 0 0 0", perf_branches, perf_mispredicts, out_next_pc); end
    tick; rst_n = 1'b1; out_ready = 1'b1;
    tick; tick;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got %b %b expected 0 0", out_valid, redirect_valid); end
  endtask

  initial begin
    test_reset;
    test_beq;
    test_blt;
    test_jump;
    test_illegal;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
